// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate front end: widths, op codes and the
// control word that shift_mask_gen hands to the datapath.
package shift_pkg;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned AMT_W = 5;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned OFS_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ROR = 3'd0,
    OP_ROL = 3'd1,
    OP_SRL = 3'd2,
    OP_SLL = 3'd3,
    OP_SRA = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    CS_ZERO    = 2'd0,
    CS_DATA    = 2'd1,
    CS_RES_MSB = 2'd2,
    CS_RES_LSB = 2'd3
  } carry_sel_e;

  typedef struct packed {
    logic [OFS_W-1:0] offset;
    logic [WIDTH-1:0] keep;
    logic             fill_sign;
    carry_sel_e       carry_sel;
    logic [OFS_W-1:0] carry_idx;
    logic             err;
  } shift_ctl_t;
endpackage

// File: rtl/BarrelShifter.sv
// 16-bit rotator core: out = in rotated right by offset.
module BarrelShifter (
  input  logic [15:0] in,
  input  logic [3:0]  offset,
  output logic [15:0] out
);
  logic [15:0] s;

  always_comb begin
    s = in;
    if (offset[0]) s = {s[0],   s[15:1]};
    if (offset[1]) s = {s[1:0], s[15:2]};
    if (offset[2]) s = {s[3:0], s[15:4]};
    if (offset[3]) s = {s[7:0], s[15:8]};
    out = s;
  end
endmodule

// File: rtl/shift_mask_gen.sv
// Maps {op, amt} onto a right-rotate offset, a keep mask, a fill source and
// the location of the carry bit.
module shift_mask_gen
  import shift_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [AMT_W-1:0] amt,
  output shift_ctl_t       ctl
);
  logic             amt_nz;
  logic             over16;
  logic [OFS_W-1:0] neg_amt;
  logic [OFS_W-1:0] amt_m1;
  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] keep_low;
  logic [WIDTH-1:0] keep_high;

  always_comb begin
    ones    = '1;
    amt_nz  = (amt != '0);
    over16  = amt[4] && (amt[3:0] != '0);
    // 4-bit wrap gives (16-n)&15 and (n-1)&15, correct for n in 1..16
    neg_amt = 4'd0 - amt[3:0];
    amt_m1  = amt[3:0] - 4'd1;
    keep_low  = amt[4] ? '0 : (ones >> amt[3:0]);
    keep_high = amt[4] ? '0 : (ones << amt[3:0]);

    ctl = '{offset: '0, keep: '1, fill_sign: 1'b0, carry_sel: CS_ZERO,
            carry_idx: '0, err: 1'b0};

    case (op_e'(op))
      OP_ROR: begin
        ctl.offset = amt[3:0];
        if (amt[3:0] != '0) ctl.carry_sel = CS_RES_MSB;
      end
      OP_ROL: begin
        ctl.offset = neg_amt;
        if (amt[3:0] != '0) ctl.carry_sel = CS_RES_LSB;
      end
      OP_SRL, OP_SRA: begin
        ctl.offset    = amt[3:0];
        ctl.keep      = keep_low;
        ctl.fill_sign = (op_e'(op) == OP_SRA);
        if (amt_nz && !over16) begin
          ctl.carry_sel = CS_DATA;
          ctl.carry_idx = amt_m1;
        end else if (over16 && op_e'(op) == OP_SRA) begin
          ctl.carry_sel = CS_DATA;
          ctl.carry_idx = 4'd15;
        end
      end
      OP_SLL: begin
        ctl.offset = neg_amt;
        ctl.keep   = keep_high;
        if (amt_nz && !over16) begin
          ctl.carry_sel = CS_DATA;
          ctl.carry_idx = neg_amt;
        end
      end
      default: ctl.err = 1'b1;
    endcase
  end
endmodule

// File: rtl/shift_unit_ctrl.sv
// Two-stage shift/rotate front end: S1 holds the request, S2 holds the
// rotated/masked result and flags; valid/ready on both sides, 1 op/cycle.
module shift_unit_ctrl
  import shift_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [OP_W-1:0]  in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_err
);
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic [OP_W-1:0]  s1_op_q,    s1_op_d;
  logic [AMT_W-1:0] s1_amt_q,   s1_amt_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q,  s2_data_d;
  logic             s2_carry_q, s2_carry_d;
  logic             s2_zero_q,  s2_zero_d;
  logic             s2_err_q,   s2_err_d;

  logic             s2_adv;
  logic             accept;
  shift_ctl_t       ctl;
  logic [WIDTH-1:0] rot;
  logic [WIDTH-1:0] shaped;
  logic             fill;
  logic             carry;

  shift_mask_gen u_mask (
    .op  (s1_op_q),
    .amt (s1_amt_q),
    .ctl (ctl)
  );

  BarrelShifter u_rot (
    .in     (s1_data_q),
    .offset (ctl.offset),
    .out    (rot)
  );

  always_comb begin
    fill   = ctl.fill_sign & s1_data_q[WIDTH-1];
    shaped = (rot & ctl.keep) | (~ctl.keep & {WIDTH{fill}});
    case (ctl.carry_sel)
      CS_DATA:    carry = s1_data_q[ctl.carry_idx];
      CS_RES_MSB: carry = shaped[WIDTH-1];
      CS_RES_LSB: carry = shaped[0];
      default:    carry = 1'b0;
    endcase
  end

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    in_ready = !s1_valid_q || !s2_valid_q || out_ready;
    accept   = in_valid && in_ready;

    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_op_d    = s1_op_q;
    s1_amt_d   = s1_amt_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_op_d    = in_op;
      s1_amt_d   = in_amt;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_carry_d = s2_carry_q;
    s2_zero_d  = s2_zero_q;
    s2_err_d   = s2_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d  = shaped;
        s2_carry_d = carry;
        s2_zero_d  = (shaped == '0);
        s2_err_d   = ctl.err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_op_q    <= '0;
      s1_amt_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_carry_q <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_op_q    <= s1_op_d;
      s1_amt_q   <= s1_amt_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_carry_q <= s2_carry_d;
      s2_zero_q  <= s2_zero_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_carry = s2_carry_q;
  assign out_zero  = s2_zero_q;
  assign out_err   = s2_err_q;
endmodule
